// File: rtl/windower_pkg.sv
// Shared definitions for the sample windower.
//   sample_t  : one multi-channel sample at the default geometry
//   state_t   : fill/run phases of the window scheduler
//   ptr_width : width of a pointer or counter that spans a given depth
package windower_pkg;

  localparam int DEF_NUM_CHS     = 2;
  localparam int DEF_SAMPLE_SIZE = 2;
  localparam int DEF_WINDOW_SIZE = 4;
  localparam int DEF_WINDOW_STEP = 2;
  localparam int DEF_CNT_W       = 16;

  typedef logic [DEF_NUM_CHS-1:0][DEF_SAMPLE_SIZE-1:0] sample_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A depth of 1 still needs one bit so the pointer is never zero-width.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/windower_stream_if.sv
// Bundle of stream-side signals around the windower.
//   en, samples, clear : sample input side
//   win_ready          : downstream acceptance
//   win_valid, window  : window output (window[0] = oldest sample)
//   win_count, overrun : accepted-window counter and dropped-window pulse
// Modport slave is the windower itself; master is whatever drives it.
interface windower_stream_if
  import windower_pkg::*;
#(
  parameter int NUM_CHS     = DEF_NUM_CHS,
  parameter int SAMPLE_SIZE = DEF_SAMPLE_SIZE,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int CNT_W       = DEF_CNT_W
);
  logic                                               en;
  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0]                samples;
  logic                                               clear;
  logic                                               win_ready;
  logic                                               win_valid;
  logic [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0] window;
  logic [CNT_W-1:0]                                   win_count;
  logic                                               overrun;

  modport slave (
    input  en, samples, clear, win_ready,
    output win_valid, window, win_count, overrun
  );

  modport master (
    output en, samples, clear, win_ready,
    input  win_valid, window, win_count, overrun
  );
endinterface

// File: rtl/windower_stream_sample_ring.sv
// Circular sample store with a write pointer.
//   clk, nrst : clock, asynchronous active-low reset
//   i_wr_en   : store i_sample at the write pointer and advance it
//   i_clear   : return the write pointer to 0 (wins over i_wr_en)
//   i_sample  : incoming multi-channel sample
//   o_view    : oldest-first view of the ring as it will look after the
//               current write, i.e. o_view[WINDOW_SIZE-1] is i_sample itself
module sample_ring
  import windower_pkg::*;
#(
  parameter int NUM_CHS     = DEF_NUM_CHS,
  parameter int SAMPLE_SIZE = DEF_SAMPLE_SIZE,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE
) (
  input  logic                                               clk,
  input  logic                                               nrst,
  input  logic                                               i_wr_en,
  input  logic                                               i_clear,
  input  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0]                i_sample,
  output logic [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0] o_view
);
  localparam int PW = ptr_width(WINDOW_SIZE);

  logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0] r_mem [WINDOW_SIZE];
  logic [PW-1:0]                       r_wptr;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr <= '0;
      for (int k = 0; k < WINDOW_SIZE; k++) r_mem[k] <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wptr] <= i_sample;
      r_wptr        <= (r_wptr == PW'(WINDOW_SIZE - 1)) ? '0 : r_wptr + PW'(1);
    end
  end

  // The slot about to be overwritten holds the oldest sample, so the
  // surviving history starts one past the write pointer and wraps.
  for (genvar gi = 0; gi < WINDOW_SIZE - 1; gi++) begin : g_view
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    assign w_sum = {1'b0, r_wptr} + (PW+1)'(gi + 1);
    assign w_idx = (w_sum >= (PW+1)'(WINDOW_SIZE)) ?
                   PW'(w_sum - (PW+1)'(WINDOW_SIZE)) : w_sum[PW-1:0];
    assign o_view[gi] = r_mem[w_idx];
  end
  assign o_view[WINDOW_SIZE-1] = i_sample;

endmodule

// File: rtl/windower_stream.sv
// Streaming windower: collects one multi-channel sample per en into a ring
// and emits an oldest-first window of WINDOW_SIZE samples every WINDOW_STEP
// samples over a valid/ready handshake.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : en/samples/clear/win_ready in; win_valid/window/win_count/
//               overrun out (see windower_stream_if)
// A window falling due while the previous one is still held is dropped and
// flagged on overrun; the input side is never stalled.
module windower_stream
  import windower_pkg::*;
#(
  parameter int NUM_CHS     = DEF_NUM_CHS,
  parameter int SAMPLE_SIZE = DEF_SAMPLE_SIZE,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int WINDOW_STEP = DEF_WINDOW_STEP,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  windower_stream_if.slave bus
);
  localparam int PW = ptr_width(WINDOW_SIZE);

  if (WINDOW_SIZE < 2) begin : g_bad_size
    $error("windower_stream: WINDOW_SIZE must be at least 2");
  end
  if (WINDOW_STEP < 1 || WINDOW_STEP > WINDOW_SIZE) begin : g_bad_step
    $error("windower_stream: WINDOW_STEP must lie in 1..WINDOW_SIZE");
  end

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_fill_cnt, w_fill_next;
  logic [PW-1:0] r_step_cnt, w_step_next;
  logic          w_due;

  logic [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0] w_view, r_window;
  logic             r_win_valid;
  logic             r_overrun;
  logic [CNT_W-1:0] r_win_count;
  logic             w_transfer;
  logic             w_held;

  sample_ring #(
    .NUM_CHS    (NUM_CHS),
    .SAMPLE_SIZE(SAMPLE_SIZE),
    .WINDOW_SIZE(WINDOW_SIZE)
  ) u_ring (
    .clk     (clk),
    .nrst    (nrst),
    .i_wr_en (bus.en),
    .i_clear (bus.clear),
    .i_sample(bus.samples),
    .o_view  (w_view)
  );

  assign w_transfer = r_win_valid & bus.win_ready;
  assign w_held     = r_win_valid & ~bus.win_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= FILL;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fill_next  = r_fill_cnt;
    w_step_next  = r_step_cnt;
    w_due        = 1'b0;
    if (bus.clear) begin
      w_state_next = FILL;
      w_fill_next  = '0;
      w_step_next  = '0;
    end else if (bus.en) begin
      case (r_state)
        FILL: begin
          if (r_fill_cnt == PW'(WINDOW_SIZE - 1)) begin
            w_due        = 1'b1;
            w_state_next = RUN;
            w_fill_next  = '0;
            w_step_next  = '0;
          end else begin
            w_fill_next = r_fill_cnt + PW'(1);
          end
        end
        RUN: begin
          if (r_step_cnt == PW'(WINDOW_STEP - 1)) begin
            w_due       = 1'b1;
            w_step_next = '0;
          end else begin
            w_step_next = r_step_cnt + PW'(1);
          end
        end
        default: w_state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fill_cnt <= '0;
      r_step_cnt <= '0;
    end else begin
      r_fill_cnt <= w_fill_next;
      r_step_cnt <= w_step_next;
    end
  end

  // A load on a transfer edge replaces the accepted window, so valid stays
  // high; a due window with the output held is lost and only flagged.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_window    <= '0;
      r_win_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_win_count <= '0;
    end else begin
      r_overrun <= 1'b0;
      if (w_transfer) r_win_count <= r_win_count + CNT_W'(1);
      if (bus.clear) begin
        r_win_valid <= 1'b0;
      end else if (w_due && !w_held) begin
        r_window    <= w_view;
        r_win_valid <= 1'b1;
      end else if (w_due) begin
        r_overrun <= 1'b1;
      end else if (w_transfer) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  assign bus.win_valid = r_win_valid;
  assign bus.window    = r_window;
  assign bus.win_count = r_win_count;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_windower_stream.sv
// Bench for windower_stream: three instances (WINDOW_STEP = 2, 1, 4) share
// one stimulus. Directed vectors and sequences target the STEP=2 instance
// and the STEP=1/4 corner configurations; a random phase checks all three
// against a sample-history model of the windowing rules.
module tb_windower_stream;
  import windower_pkg::*;

  localparam int WS = 4;
  localparam int NC = 2;
  localparam int SS = 2;
  localparam int CW = 16;
  localparam int STEPS [3] = '{2, 1, 4};

  logic    clk = 1'b0;
  logic    nrst = 1'b0;
  logic    en_s = 1'b0;
  logic    clr_s = 1'b0;
  logic    rdy_s = 1'b0;
  sample_t smp_s = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  windower_stream_if #(.NUM_CHS(NC), .SAMPLE_SIZE(SS), .WINDOW_SIZE(WS), .CNT_W(CW))
    bus_s2(), bus_s1(), bus_s4();

  assign bus_s2.en = en_s;  assign bus_s2.samples = smp_s;
  assign bus_s2.clear = clr_s;  assign bus_s2.win_ready = rdy_s;
  assign bus_s1.en = en_s;  assign bus_s1.samples = smp_s;
  assign bus_s1.clear = clr_s;  assign bus_s1.win_ready = rdy_s;
  assign bus_s4.en = en_s;  assign bus_s4.samples = smp_s;
  assign bus_s4.clear = clr_s;  assign bus_s4.win_ready = rdy_s;

  windower_stream #(.NUM_CHS(NC), .SAMPLE_SIZE(SS), .WINDOW_SIZE(WS),
                    .WINDOW_STEP(2), .CNT_W(CW))
    dut_s2 (.clk(clk), .nrst(nrst), .bus(bus_s2.slave));
  windower_stream #(.NUM_CHS(NC), .SAMPLE_SIZE(SS), .WINDOW_SIZE(WS),
                    .WINDOW_STEP(1), .CNT_W(CW))
    dut_s1 (.clk(clk), .nrst(nrst), .bus(bus_s1.slave));
  windower_stream #(.NUM_CHS(NC), .SAMPLE_SIZE(SS), .WINDOW_SIZE(WS),
                    .WINDOW_STEP(4), .CNT_W(CW))
    dut_s4 (.clk(clk), .nrst(nrst), .bus(bus_s4.slave));

  logic        act_v [3];
  logic        act_ov[3];
  logic [15:0] act_w [3];
  logic [15:0] act_c [3];
  assign act_v[0] = bus_s2.win_valid;  assign act_w[0] = bus_s2.window;
  assign act_c[0] = bus_s2.win_count;  assign act_ov[0] = bus_s2.overrun;
  assign act_v[1] = bus_s1.win_valid;  assign act_w[1] = bus_s1.window;
  assign act_c[1] = bus_s1.win_count;  assign act_ov[1] = bus_s1.overrun;
  assign act_v[2] = bus_s4.win_valid;  assign act_w[2] = bus_s4.window;
  assign act_c[2] = bus_s4.win_count;  assign act_ov[2] = bus_s4.overrun;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit e, input logic [1:0] v, input bit c, input bit r);
    en_s  = e;
    smp_s = {v, v};
    clr_s = c;
    rdy_s = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    en_s = 1'b0; clr_s = 1'b0; rdy_s = 1'b0;
    nrst = 1'b0;
    #2;
    nrst = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Each instance keeps the last WS samples since the last flush and the
  // number of samples taken since then; a window is due when that number
  // reaches WS and then every STEP samples after.
  bit          m_v [3];
  bit          m_ov[3];
  logic [15:0] m_w [3];
  logic [15:0] m_c [3];
  int          m_n [3];
  logic [3:0]  m_h [3][WS];

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_v[c] = 1'b0; m_ov[c] = 1'b0; m_w[c] = '0; m_c[c] = '0; m_n[c] = 0;
      for (int k = 0; k < WS; k++) m_h[c][k] = '0;
    end
  endtask

  task automatic model_step();
    bit fer, held, due;
    for (int c = 0; c < 3; c++) begin
      fer  = m_v[c] && rdy_s;
      held = m_v[c] && !rdy_s;
      due  = 1'b0;
      m_ov[c] = 1'b0;
      if (fer) m_c[c] = m_c[c] + 16'd1;
      if (clr_s) begin
        m_n[c] = 0;
        m_v[c] = 1'b0;
      end else begin
        if (en_s) begin
          for (int k = 0; k < WS - 1; k++) m_h[c][k] = m_h[c][k+1];
          m_h[c][WS-1] = smp_s;
          m_n[c]++;
          due = (m_n[c] >= WS) && (((m_n[c] - WS) % STEPS[c]) == 0);
        end
        if (due && !held) begin
          m_w[c] = {m_h[c][3], m_h[c][2], m_h[c][1], m_h[c][0]};
          m_v[c] = 1'b1;
        end else if (due) begin
          m_ov[c] = 1'b1;
        end else if (fer) begin
          m_v[c] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- directed vector table (STEP=2 instance) ----------------
  typedef struct {
    bit          en;
    logic [1:0]  s;
    bit          clr;
    bit          rdy;
    bit          v;
    logic [15:0] w;
    logic [15:0] c;
    bit          ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input logic [1:0] s, input bit c, input bit r,
                     input bit v, input logic [15:0] w, input logic [15:0] cnt, input bit ov);
    vec_t x;
    x.en = e; x.s = s; x.clr = c; x.rdy = r; x.v = v; x.w = w; x.c = cnt; x.ov = ov;
    tbl.push_back(x);
  endtask

  // Oldest-first windows with both channels equal, index 0 in the low bits.
  localparam logic [15:0] W1230 = 16'h0FA5;
  localparam logic [15:0] W3012 = 16'hA50F;
  localparam logic [15:0] W2310 = 16'h05FA;

  initial begin
    int seq[8];
    logic [3:0] v4;
    bit e, c, r;

    // Basic stream, ready always high.
    add(1,1,0,1, 0,16'h0000,0,0);
    add(1,2,0,1, 0,16'h0000,0,0);
    add(1,3,0,1, 0,16'h0000,0,0);
    add(1,0,0,1, 1,W1230,0,0);
    add(1,1,0,1, 0,W1230,1,0);
    add(1,2,0,1, 1,W3012,1,0);
    add(1,3,0,1, 0,W3012,2,0);
    add(1,0,0,1, 1,W1230,2,0);
    add(0,0,0,1, 0,W1230,3,0);
    // Flush (the en on this edge is ignored), then backpressure from sample 4.
    add(1,3,1,1, 0,W1230,3,0);
    add(1,1,0,1, 0,W1230,3,0);
    add(1,2,0,1, 0,W1230,3,0);
    add(1,3,0,1, 0,W1230,3,0);
    add(1,0,0,0, 1,W1230,3,0);
    add(1,1,0,0, 1,W1230,3,0);
    add(1,2,0,0, 1,W1230,3,1);
    add(1,3,0,0, 1,W1230,3,0);
    add(1,0,0,0, 1,W1230,3,1);
    add(0,0,0,1, 0,W1230,4,0);
    // Transfer on the same edge that completes sample 6.
    add(0,0,1,0, 0,W1230,4,0);
    add(1,1,0,0, 0,W1230,4,0);
    add(1,2,0,0, 0,W1230,4,0);
    add(1,3,0,0, 0,W1230,4,0);
    add(1,0,0,0, 1,W1230,4,0);
    add(1,1,0,0, 1,W1230,4,0);
    add(1,2,0,1, 1,W3012,5,0);
    add(0,0,0,1, 0,W3012,6,0);
    // Clear after sample 5; the next window holds only the following 4.
    add(0,0,1,1, 0,W3012,6,0);
    add(1,1,0,1, 0,W3012,6,0);
    add(1,2,0,1, 0,W3012,6,0);
    add(1,3,0,1, 0,W3012,6,0);
    add(1,0,0,1, 1,W1230,6,0);
    add(1,1,0,1, 0,W1230,7,0);
    add(1,1,1,1, 0,W1230,7,0);
    add(1,2,0,1, 0,W1230,7,0);
    add(1,3,0,1, 0,W1230,7,0);
    add(1,1,0,1, 0,W1230,7,0);
    add(1,0,0,1, 1,W2310,7,0);
    add(0,0,0,1, 0,W2310,8,0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", bus_s2.win_valid, 0);
    check("reset window", bus_s2.window, 0);
    check("reset count", bus_s2.win_count, 0);
    check("reset overrun", bus_s2.overrun, 0);
    check("reset valid step1", bus_s1.win_valid, 0);
    check("reset valid step4", bus_s4.win_valid, 0);
    nrst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].s, tbl[i].clr, tbl[i].rdy);
      check($sformatf("vec%0d valid", i), bus_s2.win_valid, tbl[i].v);
      check($sformatf("vec%0d window", i), bus_s2.window, tbl[i].w);
      check($sformatf("vec%0d count", i), bus_s2.win_count, tbl[i].c);
      check($sformatf("vec%0d overrun", i), bus_s2.overrun, tbl[i].ov);
    end

    // Asynchronous reset between clock edges, mid-window.
    drive(1, 1, 0, 1);
    drive(1, 2, 0, 1);
    en_s = 1'b0;
    #1;
    nrst = 1'b0;
    #1;
    check("async valid", bus_s2.win_valid, 0);
    check("async window", bus_s2.window, 0);
    check("async count", bus_s2.win_count, 0);
    check("async overrun", bus_s2.overrun, 0);
    check("async count step4", bus_s4.win_count, 0);
    #1;
    nrst = 1'b1;
    drive(1, 3, 0, 1);
    check("refill1 valid", bus_s2.win_valid, 0);
    drive(1, 0, 0, 1);
    check("refill2 valid", bus_s2.win_valid, 0);
    drive(1, 1, 0, 1);
    check("refill3 valid", bus_s2.win_valid, 0);
    drive(1, 2, 0, 1);
    check("refill4 valid", bus_s2.win_valid, 1);
    check("refill4 window", bus_s2.window, W3012);
    check("refill4 count", bus_s2.win_count, 0);

    // STEP=1 and STEP=4 configurations.
    pulse_reset();
    seq = '{1, 2, 3, 0, 2, 3, 0, 1};
    for (int k = 1; k <= 8; k++) begin
      drive(1, 2'(seq[k-1]), 0, 1);
      check($sformatf("step1 s%0d valid", k), bus_s1.win_valid, (k >= 4) ? 1 : 0);
      check($sformatf("step1 s%0d count", k), bus_s1.win_count, (k >= 4) ? k - 4 : 0);
      check($sformatf("step4 s%0d valid", k), bus_s4.win_valid, (k == 4 || k == 8) ? 1 : 0);
      if (k == 5) check("step1 s5 window", bus_s1.window, 16'hA0FA);
      if (k == 4) check("step4 s4 window", bus_s4.window, W1230);
      if (k == 8) begin
        check("step4 s8 window", bus_s4.window, 16'h50FA);
        check("step4 s8 count", bus_s4.win_count, 1);
      end
    end

    // Random stream against the model, all three configurations.
    pulse_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 39) == 0);
      r  = c ? 1'b0 : ($urandom_range(0, 9) < 7);
      v4 = 4'($urandom_range(0, 15));
      en_s = e; clr_s = c; rdy_s = r; smp_s = v4;
      @(posedge clk);
      model_step();
      #1;
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rnd%0d step%0d valid", i, STEPS[k]), act_v[k], m_v[k]);
        check($sformatf("rnd%0d step%0d count", i, STEPS[k]), act_c[k], m_c[k]);
        check($sformatf("rnd%0d step%0d overrun", i, STEPS[k]), act_ov[k], m_ov[k]);
        if (m_v[k])
          check($sformatf("rnd%0d step%0d window", i, STEPS[k]), act_w[k], m_w[k]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/windower_stream.md
Name: windower_stream

Overview:
Parametrised successor to the sample windower.
- Accepts one multi-channel sample per enable pulse into a circular buffer.
- Emits an overlapping window of WINDOW_SIZE samples every WINDOW_STEP samples, ordered oldest-first.
- Adds a valid/ready output handshake, an overrun indication, a synchronous flush and a window counter.
- Sits between the ADC sample front-end and the HDC encoder/bundler.

Parameters:
NUM_CHS, 2, number of channels per sample
SAMPLE_SIZE, 2, bits per channel sample
WINDOW_SIZE, 4, samples per window (>=2)
WINDOW_STEP, 2, new samples between windows (1..WINDOW_SIZE; elaboration error otherwise)
CNT_W, 16, width of window counter

Ports:
clk  in  1  clock (one clock domain)
nrst  in  1  asynchronous active-low reset
en  in  1  sample strobe; samples captured on rising clk when high
samples  in  [NUM_CHS-1:0][SAMPLE_SIZE-1:0]  current multi-channel sample
clear  in  1  synchronous flush; priority over en
win_ready  in  1  downstream accepts window
win_valid  out  1  window output valid
window  out  [WINDOW_SIZE-1:0][NUM_CHS-1:0][SAMPLE_SIZE-1:0]  index 0 = oldest sample
win_count  out  CNT_W  windows accepted downstream, wraps modulo 2^CNT_W
overrun  out  1  one-cycle pulse when a due window is dropped

Behaviour:
- Reset (nrst low, async): ring memory, write pointer, fill and step counters, window, win_count = 0; win_valid = 0; overrun = 0; state FILL.
- States:
  - FILL: fill counter increments per en. On the en that stores the WINDOW_SIZE-th sample, a window is due; go to RUN and reset the step counter.
  - RUN: step counter increments per en. On the en completing WINDOW_STEP samples, a window is due; step counter returns to 0.
- Ring: write pointer advances modulo WINDOW_SIZE on each en.
- Window load: when a window is due, the output register loads the window, including the sample captured on that edge, reordered oldest-first. win_valid rises the next cycle (latency 1 clk after the completing en edge).
- Handshake: a transfer occurs on an edge where win_valid && win_ready.
  - On transfer: win_valid drops unless a new window loads on the same edge; win_count increments.
  - window and win_valid hold stable while win_valid && !win_ready.
- Due window while the output is held (win_valid && !win_ready):
  - The new window is dropped and the old window is kept.
  - overrun pulses for one cycle.
  - Ring and counters still advance; input is never stalled.
- Due window on the same edge as a transfer: the new window loads, win_valid stays 1, no overrun.
- clear:
  - Pointers, fill and step counters and win_valid go to 0; state returns to FILL.
  - Memory contents need not be zeroed.
  - win_count is kept.
  - Any en on the same edge is ignored.
- en while in reset has no effect. Reset mid-window discards the partial window.
- samples must be stable only at sampling edges; no combinational path from inputs to outputs.

Decomposition:
- Package windower_pkg holds:
  - typedef sample_t = logic [NUM_CHS-1:0][SAMPLE_SIZE-1:0], parametrised via defaults matching the module;
  - FSM enum state_t {FILL, RUN};
  - a function computing clog2-based pointer width.
- Sub-module sample_ring:
  - Circular storage with write pointer.
  - Combinational oldest-first unrolled view.
  - windower_stream adds the FSM, handshake and counters.

Test Plan:
All scenarios use default parameters, with both channels driven equal.
- Basic stream, win_ready=1, sample sequence 1,2,3,0,1,2,3,0:
  - windows [1,2,3,0] after sample 4, [3,0,1,2] after sample 6, [1,2,3,0] after sample 8;
  - each win_valid lasts 1 cycle, 1 clk after the completing en;
  - win_count ends at 3.
- Backpressure, win_ready=0 from sample 4 on, same sequence:
  - window [1,2,3,0] holds;
  - overrun pulses after samples 6 and 8;
  - raising win_ready transfers [1,2,3,0]; win_count=1.
- Simultaneous transfer and due window:
  - hold window 1, then raise win_ready on the edge sample 6 completes;
  - win_valid stays 1 and window becomes [3,0,1,2]; no overrun.
- clear after sample 5:
  - win_valid=0;
  - next window appears only after 4 further samples, containing exactly those 4 in order.
- Async reset mid-stream (nrst low between clock edges):
  - all outputs 0 immediately, win_count=0;
  - refill requires 4 samples.
- WINDOW_STEP=1 and WINDOW_STEP=WINDOW_SIZE=4 configurations:
  - STEP=1: a window follows every sample after fill;
  - STEP=4: non-overlapping windows [s1..s4], [s5..s8].
